// File: rtl/alu_issue_ctrl_if.sv
// Instruction-delivery and ALU-issue signal bundle for alu_issue_ctrl.
// master is the controller's view; slave is the instruction source / ALU side.
interface alu_issue_ctrl_if;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] alu_instruction;
  logic [31:0] alu_pc;
  logic [31:0] alu_rs1_data;
  logic [31:0] alu_rs2_data;
  logic        alu_valid;
  logic [31:0] alu_result;
  logic [31:0] alu_next_pc;
  logic        alu_result_valid;
  logic        alu_is_jump;

  modport master (
    input  instr_valid, instr, alu_result, alu_next_pc, alu_result_valid, alu_is_jump,
    output instr_ready, alu_instruction, alu_pc, alu_rs1_data, alu_rs2_data, alu_valid
  );

  modport slave (
    output instr_valid, instr, alu_result, alu_next_pc, alu_result_valid, alu_is_jump,
    input  instr_ready, alu_instruction, alu_pc, alu_rs1_data, alu_rs2_data, alu_valid
  );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Single-issue controller: takes RV32 instructions, reads operands from a 32x32
// register file, issues them to the ALU, then writes the result back and advances the PC.
module alu_issue_ctrl #(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  alu_issue_ctrl_if.master        bus,
  output logic                    retire,
  output logic [31:0]             retire_pc,
  output logic                    retire_jump,
  output logic                    illegal_instr,
  output logic                    timeout_err,
  output logic [31:0]             pc_out,
  input  logic                    dbg_we,
  input  logic [4:0]              dbg_waddr,
  input  logic [31:0]             dbg_wdata,
  input  logic [4:0]              dbg_raddr,
  output logic [31:0]             dbg_rdata
);

  localparam logic [6:0]        OPC_OP   = 7'h33;
  localparam logic [6:0]        OPC_JAL  = 7'h6F;
  localparam int unsigned       CNT_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT
  } state_t;

  state_t                 state;
  state_t                 state_next;
  logic [31:0][31:0]      regs;
  logic [CNT_W-1:0]       wait_cnt;
  logic                   accept_legal;
  logic                   accept_illegal;
  logic                   result_take;
  logic                   timeout_hit;
  logic                   dbg_commit;
  logic                   opcode_ok;
  logic [4:0]             rs1_idx;
  logic [4:0]             rs2_idx;
  logic [4:0]             rd_idx;

  assign opcode_ok = (bus.instr[6:0] == OPC_OP) || (bus.instr[6:0] == OPC_JAL);
  assign rs1_idx   = bus.instr[19:15];
  assign rs2_idx   = bus.instr[24:20];
  assign rd_idx    = bus.alu_instruction[11:7];

  assign bus.instr_ready = (state == S_IDLE);
  assign dbg_rdata       = (dbg_raddr == 5'd0) ? 32'd0 : regs[dbg_raddr];

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // An accepted instruction always wins over a debug write in the same cycle.
  always_comb begin
    state_next     = state;
    accept_legal   = 1'b0;
    accept_illegal = 1'b0;
    result_take    = 1'b0;
    timeout_hit    = 1'b0;
    dbg_commit     = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (bus.instr_valid) begin
          if (opcode_ok) begin
            accept_legal = 1'b1;
            state_next   = S_ISSUE;
          end else begin
            accept_illegal = 1'b1;
          end
        end
        dbg_commit = dbg_we && !bus.instr_valid && (dbg_waddr != 5'd0);
      end
      S_ISSUE: begin
        state_next = S_WAIT;
      end
      S_WAIT: begin
        if (bus.alu_result_valid) begin
          result_take = 1'b1;
          state_next  = S_IDLE;
        end else if (wait_cnt == CNT_LAST) begin
          timeout_hit = 1'b1;
          state_next  = S_IDLE;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.alu_instruction <= 32'd0;
      bus.alu_pc          <= 32'd0;
      bus.alu_rs1_data    <= 32'd0;
      bus.alu_rs2_data    <= 32'd0;
      bus.alu_valid       <= 1'b0;
      wait_cnt            <= '0;
    end else begin
      bus.alu_valid <= accept_legal;
      if (accept_legal) begin
        bus.alu_instruction <= bus.instr;
        bus.alu_pc          <= pc_out;
        bus.alu_rs1_data    <= (rs1_idx == 5'd0) ? 32'd0 : regs[rs1_idx];
        bus.alu_rs2_data    <= (rs2_idx == 5'd0) ? 32'd0 : regs[rs2_idx];
      end
      if (state == S_ISSUE) begin
        wait_cnt <= '0;
      end else if (state == S_WAIT) begin
        wait_cnt <= wait_cnt + CNT_W'(1);
      end
    end
  end

  // Timeout and illegal opcodes both skip the instruction by stepping the PC.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_out        <= RESET_PC;
      retire        <= 1'b0;
      retire_pc     <= 32'd0;
      retire_jump   <= 1'b0;
      illegal_instr <= 1'b0;
      timeout_err   <= 1'b0;
    end else begin
      retire        <= result_take;
      illegal_instr <= accept_illegal;
      if (result_take) begin
        pc_out      <= bus.alu_next_pc;
        retire_pc   <= bus.alu_pc;
        retire_jump <= bus.alu_is_jump;
      end else if (accept_illegal || timeout_hit) begin
        pc_out <= pc_out + 32'd4;
      end
      if (timeout_hit) begin
        timeout_err <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      regs <= '0;
    end else if (result_take && (rd_idx != 5'd0)) begin
      regs[rd_idx] <= bus.alu_result;
    end else if (dbg_commit) begin
      regs[dbg_waddr] <= dbg_wdata;
    end
  end

endmodule
